// File: rtl/ped_walk_render_if.sv
// Pedestrian walk stream plus rendered strip/status outputs.
// master = walk controller side, slave = renderer side.
interface ped_walk_render_if #(
    parameter int N_LEDS = 16,
    parameter int CNT_W  = 8
);
    logic              ped_active;
    logic [1:0]        ped_sel;
    logic [7:0]        ped_phase;
    logic              err_clr;
    logic [N_LEDS-1:0] led_ns;
    logic [N_LEDS-1:0] led_ew;
    logic              trip_start;
    logic              trip_done;
    logic [1:0]        trip_dir;
    logic [CNT_W-1:0]  ns_trips;
    logic [CNT_W-1:0]  ew_trips;
    logic              proto_err;

    modport master (
        output ped_active, ped_sel, ped_phase, err_clr,
        input  led_ns, led_ew, trip_start, trip_done,
        input  trip_dir, ns_trips, ew_trips, proto_err
    );

    modport slave (
        input  ped_active, ped_sel, ped_phase, err_clr,
        output led_ns, led_ew, trip_start, trip_done,
        output trip_dir, ns_trips, ew_trips, proto_err
    );
endinterface

// File: rtl/ped_walk_render.sv
// Walk stream consumer: trip tracking, one-hot LED walker,
// trip pulses, saturating per-direction trip counters, sticky error.
module ped_walk_render #(
    parameter int N_LEDS = 16,
    parameter int CNT_W  = 8
) (
    input logic              clk,
    input logic              rst_n,
    ped_walk_render_if.slave bus
);
    localparam int PW = $clog2(N_LEDS);
    localparam int SH = 8 - PW;
    localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        IGNORE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        dir_q, dir_d;
    logic [7:0]        prev_q, prev_d;
    logic [N_LEDS-1:0] ns_led_q, ns_led_d;
    logic [N_LEDS-1:0] ew_led_q, ew_led_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic [1:0]        tdir_q, tdir_d;
    logic [CNT_W-1:0]  ns_cnt_q, ns_cnt_d;
    logic [CNT_W-1:0]  ew_cnt_q, ew_cnt_d;
    logic              err_q, err_d;

    logic              act;
    logic [1:0]        sel;
    logic [7:0]        ph;
    logic              sel_ok;
    logic              viol;
    logic [PW-1:0]     pos;
    logic [N_LEDS-1:0] dot;

    assign act    = bus.ped_active;
    assign sel    = bus.ped_sel;
    assign ph     = bus.ped_phase;
    assign sel_ok = (sel == 2'b01) || (sel == 2'b10);
    assign pos    = PW'(ph >> SH);
    assign dot    = ONE << pos;

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        prev_d   = prev_q;
        start_d  = 1'b0;
        done_d   = 1'b0;
        tdir_d   = tdir_q;
        ns_cnt_d = ns_cnt_q;
        ew_cnt_d = ew_cnt_q;
        viol     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (act) begin
                    if (sel_ok && ph == 8'd0) begin
                        state_d = TRACK;
                        dir_d   = sel;
                        tdir_d  = sel;
                        start_d = 1'b1;
                        prev_d  = 8'd0;
                    end else begin
                        viol    = 1'b1;
                        state_d = IGNORE;
                    end
                end
            end
            TRACK: begin
                if (prev_q == 8'hFF) begin
                    if (!act) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (ph == 8'd0 && sel_ok) begin
                        // back-to-back: close old trip, open new one
                        done_d  = 1'b1;
                        start_d = 1'b1;
                        dir_d   = sel;
                        tdir_d  = sel;
                        prev_d  = 8'd0;
                    end else if (!(ph == 8'hFF && sel == dir_q)) begin
                        viol = 1'b1;
                    end
                end else if (act && sel == dir_q &&
                             (ph == prev_q || ph == prev_q + 8'd1)) begin
                    prev_d = ph;
                end else begin
                    viol = 1'b1;
                end
                if (viol) begin
                    state_d = act ? IGNORE : IDLE;
                    prev_d  = 8'd0;
                end
            end
            IGNORE: begin
                if (!act) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (done_d) begin
            if (dir_q == 2'b01) begin
                ns_cnt_d = (&ns_cnt_q) ? ns_cnt_q : ns_cnt_q + 1'b1;
            end else begin
                ew_cnt_d = (&ew_cnt_q) ? ew_cnt_q : ew_cnt_q + 1'b1;
            end
        end

        err_d = viol | (err_q & ~bus.err_clr);

        ns_led_d = '0;
        ew_led_d = '0;
        if (state_d == TRACK) begin
            if (dir_d == 2'b01) ns_led_d = dot;
            else                ew_led_d = dot;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dir_q    <= 2'b00;
            prev_q   <= 8'd0;
            ns_led_q <= '0;
            ew_led_q <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            tdir_q   <= 2'b00;
            ns_cnt_q <= '0;
            ew_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            prev_q   <= prev_d;
            ns_led_q <= ns_led_d;
            ew_led_q <= ew_led_d;
            start_q  <= start_d;
            done_q   <= done_d;
            tdir_q   <= tdir_d;
            ns_cnt_q <= ns_cnt_d;
            ew_cnt_q <= ew_cnt_d;
            err_q    <= err_d;
        end
    end

    assign bus.led_ns     = ns_led_q;
    assign bus.led_ew     = ew_led_q;
    assign bus.trip_start = start_q;
    assign bus.trip_done  = done_q;
    assign bus.trip_dir   = tdir_q;
    assign bus.ns_trips   = ns_cnt_q;
    assign bus.ew_trips   = ew_cnt_q;
    assign bus.proto_err  = err_q;
endmodule

// File: tb/tb_ped_walk_render.sv
// Scoreboard bench for ped_walk_render (N_LEDS=16, CNT_W=2).
// Driver queues the expected registered response; monitor pops.
module tb_ped_walk_render;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    ped_walk_render_if #(.N_LEDS(16), .CNT_W(2)) bus ();

    ped_walk_render #(.N_LEDS(16), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] lns;
        logic [15:0] lew;
        logic        st;
        logic        dn;
        logic [1:0]  dir;
        logic [1:0]  nsc;
        logic [1:0]  ewc;
        logic        err;
        string       tag;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int checks = 0;
    int errors = 0;

    logic [1:0] e_dir = 2'b00;
    logic [1:0] e_ns  = 2'd0;
    logic [1:0] e_ew  = 2'd0;
    logic       e_err = 1'b0;

    function automatic logic [15:0] dot(input logic [7:0] p);
        logic [15:0] one;
        one = 16'd1;
        return one << (p >> 4);
    endfunction

    function automatic logic [1:0] sat(input logic [1:0] c);
        return (c == 2'd3) ? c : c + 2'd1;
    endfunction

    task automatic drive(input logic a, input logic [1:0] s,
                         input logic [7:0] p, input logic clr,
                         input logic [15:0] ln, input logic [15:0] le,
                         input logic st, input logic dn, input string tag);
        exp_t e;
        @(negedge clk);
        bus.ped_active = a;
        bus.ped_sel    = s;
        bus.ped_phase  = p;
        bus.err_clr    = clr;
        e.lns = ln; e.lew = le; e.st = st; e.dn = dn;
        e.dir = e_dir; e.nsc = e_ns; e.ewc = e_ew; e.err = e_err;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 2'b00, 8'd0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, tag);
    endtask

    task automatic walk(input logic [1:0] s, input int hold,
                        input bit b2b, input int last);
        for (int ph = 0; ph <= last; ph++) begin
            for (int h = 0; h < hold; h++) begin
                bit first;
                first = (ph == 0 && h == 0);
                if (first) begin
                    if (b2b) begin
                        if (e_dir == 2'b01) e_ns = sat(e_ns);
                        else                e_ew = sat(e_ew);
                    end
                    e_dir = s;
                end
                drive(1'b1, s, 8'(ph), 1'b0,
                      (s == 2'b01) ? dot(8'(ph)) : 16'h0,
                      (s == 2'b10) ? dot(8'(ph)) : 16'h0,
                      first, first && b2b, "walk");
            end
        end
    endtask

    task automatic finish_trip;
        if (e_dir == 2'b01) e_ns = sat(e_ns);
        else                e_ew = sat(e_ew);
        drive(1'b0, e_dir, 8'd0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1, "done");
        idle("after_done");
    endtask

    task automatic do_reset;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        bus.ped_active = 1'b0;
        bus.err_clr    = 1'b0;
        #1;
        checks++;
        if (bus.led_ns != 0 || bus.led_ew != 0 || bus.trip_start ||
            bus.trip_done || bus.trip_dir != 0 || bus.ns_trips != 0 ||
            bus.ew_trips != 0 || bus.proto_err) begin
            errors++;
            $display("FAIL async_reset: got ns=%h ew=%h st=%b dn=%b dir=%b n=%0d e=%0d err=%b, want all 0",
                     bus.led_ns, bus.led_ew, bus.trip_start, bus.trip_done,
                     bus.trip_dir, bus.ns_trips, bus.ew_trips, bus.proto_err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e_dir = 2'b00; e_ns = 2'd0; e_ew = 2'd0; e_err = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                m = q.pop_front();
                checks++;
                if (bus.led_ns !== m.lns || bus.led_ew !== m.lew ||
                    bus.trip_start !== m.st || bus.trip_done !== m.dn ||
                    bus.trip_dir !== m.dir || bus.ns_trips !== m.nsc ||
                    bus.ew_trips !== m.ewc || bus.proto_err !== m.err) begin
                    errors++;
                    $display("FAIL %s @%0t: got ns=%h ew=%h st=%b dn=%b dir=%b n=%0d e=%0d err=%b want ns=%h ew=%h st=%b dn=%b dir=%b n=%0d e=%0d err=%b",
                             m.tag, $time, bus.led_ns, bus.led_ew,
                             bus.trip_start, bus.trip_done, bus.trip_dir,
                             bus.ns_trips, bus.ew_trips, bus.proto_err,
                             m.lns, m.lew, m.st, m.dn, m.dir, m.nsc,
                             m.ewc, m.err);
                end
            end
        end
    end

    initial begin
        bus.ped_active = 1'b0;
        bus.ped_sel    = 2'b00;
        bus.ped_phase  = 8'd0;
        bus.err_clr    = 1'b0;
        do_reset();
        idle("reset_idle");

        // NS trip, 4 cycles per phase, then drop active
        walk(2'b01, 4, 1'b0, 255);
        finish_trip();

        // NS then EW back-to-back
        do_reset();
        walk(2'b01, 1, 1'b0, 255);
        walk(2'b10, 1, 1'b1, 255);
        finish_trip();

        // phase jump 10 -> 12, ignore until active drops, clear error
        do_reset();
        walk(2'b01, 1, 1'b0, 10);
        e_err = 1'b1;
        drive(1'b1, 2'b01, 8'd12, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "jump");
        drive(1'b1, 2'b01, 8'd13, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "ignored");
        idle("drop");
        e_err = 1'b0;
        drive(1'b0, 2'b00, 8'd0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0, "err_clr");
        walk(2'b01, 1, 1'b0, 255);
        finish_trip();

        // active drop before 255 aborts without counting
        walk(2'b10, 1, 1'b0, 100);
        e_err = 1'b1;
        idle("early_drop");

        // bad starts; violation beats simultaneous err_clr
        do_reset();
        e_err = 1'b1;
        drive(1'b1, 2'b01, 8'd5, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, "start_nz");
        idle("drop_nz");
        e_err = 1'b0;
        drive(1'b0, 2'b00, 8'd0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0, "clr_nz");
        e_err = 1'b1;
        drive(1'b1, 2'b11, 8'd0, 1'b1, 16'h0, 16'h0, 1'b0, 1'b0, "sel11_clr");
        idle("drop_sel11");

        // counter saturation at CNT_W=2
        do_reset();
        for (int t = 0; t < 4; t++) begin
            walk(2'b01, 1, 1'b0, 255);
            finish_trip();
        end

        // reset mid-trip at phase 128, then clean trip
        do_reset();
        walk(2'b01, 1, 1'b0, 128);
        do_reset();
        walk(2'b01, 1, 1'b0, 255);
        finish_trip();

        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
